// File: rtl/pic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pic_pkg                                                |
// | Description : Shared types and constants for the PIC read/write      |
// |               logic: FSM state encoding, flag bit indices and        |
// |               read-select values.                                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package pic_pkg;

   // Write-sequencing FSM states
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_ICW2 = 3'd1,
      ST_WAIT_ICW3 = 3'd2,
      ST_WAIT_ICW4 = 3'd3,
      ST_READY     = 3'd4
   } state_e;

   // Bit positions inside ICWS_FLAGS
   localparam int unsigned ICW1 = 0;
   localparam int unsigned ICW2 = 1;
   localparam int unsigned ICW3 = 2;
   localparam int unsigned ICW4 = 3;

   // Bit positions inside OCWS_FLAGS
   localparam int unsigned OCW1 = 0;
   localparam int unsigned OCW2 = 1;
   localparam int unsigned OCW3 = 2;

   // Read-back register select
   localparam logic SEL_IRR = 1'b0;
   localparam logic SEL_ISR = 1'b1;

endpackage : pic_pkg
`default_nettype wire

// File: rtl/pic_wr_commit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pic_wr_commit                                          |
// | Description : Samples the CPU write strobe, chip select, A0 and the  |
// |               data bus, and flags a commit on the WR_N rising edge   |
// |               of a selected write.                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pic_wr_commit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_wr_n,
   input  logic       i_cs_n,
   input  logic       i_a0,
   input  logic [7:0] i_d,
   output logic       o_commit,
   output logic       o_a0_q,
   output logic [7:0] o_d_q
);

   logic       wr_n_q, wr_n_d;
   logic       cs_n_q, cs_n_d;
   logic       a0_q,   a0_d;
   logic [7:0] d_q,    d_d;

   // Next-state of the samples: strobes every cycle, address/data only while a selected write is active
   always_comb begin
      wr_n_d = i_wr_n;
      cs_n_d = i_cs_n;
      a0_d   = a0_q;
      d_d    = d_q;
      if (!i_wr_n && !i_cs_n) begin
         a0_d = i_a0;
         d_d  = i_d;
      end
   end

   // Sample registers; reset leaves the strobes idle so no stale write can commit
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_n_q <= 1'b1;
         cs_n_q <= 1'b1;
         a0_q   <= 1'b0;
         d_q    <= 8'h00;
      end else begin
         wr_n_q <= wr_n_d;
         cs_n_q <= cs_n_d;
         a0_q   <= a0_d;
         d_q    <= d_d;
      end
   end

   // Commit on WR_N returning high after a selected low; CS_N at this moment is don't-care
   assign o_commit = !wr_n_q && !cs_n_q && i_wr_n;
   assign o_a0_q   = a0_q;
   assign o_d_q    = d_q;

endmodule : pic_wr_commit
`default_nettype wire

// File: rtl/read_write_logic.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : read_write_logic                                       |
// | Description : CPU read/write front end of an 8259-style PIC. Decodes |
// |               committed writes into ICW/OCW pulses, sequences the    |
// |               initialisation words and muxes IRR/ISR/IMR reads.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module read_write_logic
   import pic_pkg::*;
(
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       CS_N,
   input  logic       WR_N,
   input  logic       RD_N,
   input  logic       A0,
   input  logic [7:0] D_IN,
   input  logic [7:0] IRR,
   input  logic [7:0] ISR,
   input  logic [7:0] IMR,
   output logic [7:0] DATA_OUT,
   output logic [3:0] ICWS_FLAGS,
   output logic [2:0] OCWS_FLAGS,
   output logic       INIT_DONE,
   output logic [7:0] D_OUT,
   output logic       D_OE
);

   logic       commit;
   logic       a0_q;
   logic [7:0] d_q;

   state_e     state_q,    state_d;
   logic [7:0] data_out_q, data_out_d;
   logic [3:0] icws_q,     icws_d;
   logic [2:0] ocws_q,     ocws_d;
   logic       sngl_q,     sngl_d;
   logic       ic4_q,      ic4_d;
   logic       read_sel_q, read_sel_d;
   logic       accept;

   pic_wr_commit u_wr_commit (
      .clk      (CLK),
      .rst_n    (RST_N),
      .i_wr_n   (WR_N),
      .i_cs_n   (CS_N),
      .i_a0     (A0),
      .i_d      (D_IN),
      .o_commit (commit),
      .o_a0_q   (a0_q),
      .o_d_q    (d_q)
   );

   // Commit decode: ICW1 restarts from any state, other words only count in their own state
   always_comb begin
      state_d    = state_q;
      data_out_d = data_out_q;
      icws_d     = 4'b0000;
      ocws_d     = 3'b000;
      sngl_d     = sngl_q;
      ic4_d      = ic4_q;
      read_sel_d = read_sel_q;
      accept     = 1'b0;

      if (commit) begin
         if (!a0_q && d_q[4]) begin
            icws_d[ICW1] = 1'b1;
            sngl_d       = d_q[1];
            ic4_d        = d_q[0];
            state_d      = ST_WAIT_ICW2;
            accept       = 1'b1;
         end else begin
            case (state_q)
               ST_WAIT_ICW2: begin
                  if (a0_q) begin
                     icws_d[ICW2] = 1'b1;
                     accept       = 1'b1;
                     if (!sngl_q)    state_d = ST_WAIT_ICW3;
                     else if (ic4_q) state_d = ST_WAIT_ICW4;
                     else            state_d = ST_READY;
                  end
               end
               ST_WAIT_ICW3: begin
                  if (a0_q) begin
                     icws_d[ICW3] = 1'b1;
                     accept       = 1'b1;
                     state_d      = ic4_q ? ST_WAIT_ICW4 : ST_READY;
                  end
               end
               ST_WAIT_ICW4: begin
                  if (a0_q) begin
                     icws_d[ICW4] = 1'b1;
                     accept       = 1'b1;
                     state_d      = ST_READY;
                  end
               end
               ST_READY: begin
                  if (a0_q) begin
                     ocws_d[OCW1] = 1'b1;
                     accept       = 1'b1;
                  end else if (d_q[4:3] == 2'b00) begin
                     ocws_d[OCW2] = 1'b1;
                     accept       = 1'b1;
                  end else if (d_q[4:3] == 2'b01) begin
                     ocws_d[OCW3] = 1'b1;
                     accept       = 1'b1;
                     if (d_q[1]) read_sel_d = d_q[0] ? SEL_ISR : SEL_IRR;
                  end
               end
               default: ;
            endcase
         end
      end

      if (accept) data_out_d = d_q;
   end

   // State, data and pulse registers
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q    <= ST_IDLE;
         data_out_q <= 8'h00;
         icws_q     <= 4'b0000;
         ocws_q     <= 3'b000;
         sngl_q     <= 1'b0;
         ic4_q      <= 1'b0;
         read_sel_q <= SEL_IRR;
      end else begin
         state_q    <= state_d;
         data_out_q <= data_out_d;
         icws_q     <= icws_d;
         ocws_q     <= ocws_d;
         sngl_q     <= sngl_d;
         ic4_q      <= ic4_d;
         read_sel_q <= read_sel_d;
      end
   end

   // Read path: a concurrent write strobe suppresses the bus drive
   always_comb begin
      D_OE  = !CS_N && !RD_N && WR_N;
      D_OUT = 8'h00;
      if (D_OE) begin
         if (A0)                         D_OUT = IMR;
         else if (read_sel_q == SEL_ISR) D_OUT = ISR;
         else                            D_OUT = IRR;
      end
   end

   assign DATA_OUT   = data_out_q;
   assign ICWS_FLAGS = icws_q;
   assign OCWS_FLAGS = ocws_q;
   assign INIT_DONE  = (state_q == ST_READY);

endmodule : read_write_logic
`default_nettype wire

// File: tb/tb_read_write_logic.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_read_write_logic                                    |
// | Description : Directed self-checking bench for read_write_logic.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_read_write_logic;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       CS_N = 1'b1;
   logic       WR_N = 1'b1;
   logic       RD_N = 1'b1;
   logic       A0 = 1'b0;
   logic [7:0] D_IN = 8'h00;
   logic [7:0] IRR = 8'h00;
   logic [7:0] ISR = 8'h00;
   logic [7:0] IMR = 8'h00;
   logic [7:0] DATA_OUT;
   logic [3:0] ICWS_FLAGS;
   logic [2:0] OCWS_FLAGS;
   logic       INIT_DONE;
   logic [7:0] D_OUT;
   logic       D_OE;

   int n_tests = 0;
   int n_fail  = 0;

   read_write_logic dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .CS_N       (CS_N),
      .WR_N       (WR_N),
      .RD_N       (RD_N),
      .A0         (A0),
      .D_IN       (D_IN),
      .IRR        (IRR),
      .ISR        (ISR),
      .IMR        (IMR),
      .DATA_OUT   (DATA_OUT),
      .ICWS_FLAGS (ICWS_FLAGS),
      .OCWS_FLAGS (OCWS_FLAGS),
      .INIT_DONE  (INIT_DONE),
      .D_OUT      (D_OUT),
      .D_OE       (D_OE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One full write cycle; returns sampled 1ns after the edge that registers the commit
   task automatic do_write(input logic a0, input logic [7:0] d);
      @(negedge CLK);
      CS_N = 1'b0; WR_N = 1'b0; A0 = a0; D_IN = d;
      @(negedge CLK);
      WR_N = 1'b1; CS_N = 1'b1;
      @(posedge CLK); #1;
   endtask

   // Write, check pulses/data/init, then check the pulses are gone one cycle later
   task automatic wchk(input string tag, input logic a0, input logic [7:0] d,
                       input logic [3:0] ei, input logic [2:0] eo,
                       input logic [7:0] ed, input logic einit);
      do_write(a0, d);
      chk({tag, ".icw"},  {28'd0, ICWS_FLAGS}, {28'd0, ei});
      chk({tag, ".ocw"},  {29'd0, OCWS_FLAGS}, {29'd0, eo});
      chk({tag, ".data"}, {24'd0, DATA_OUT},   {24'd0, ed});
      chk({tag, ".init"}, {31'd0, INIT_DONE},  {31'd0, einit});
      @(posedge CLK); #1;
      chk({tag, ".clr"},  {25'd0, ICWS_FLAGS, OCWS_FLAGS}, 32'd0);
   endtask

   task automatic rchk(input string tag, input logic a0, input logic [7:0] ed_out,
                       input logic eoe);
      @(negedge CLK);
      CS_N = 1'b0; RD_N = 1'b0; A0 = a0;
      #1;
      chk({tag, ".dout"}, {24'd0, D_OUT}, {24'd0, ed_out});
      chk({tag, ".doe"},  {31'd0, D_OE},  {31'd0, eoe});
      CS_N = 1'b1; RD_N = 1'b1;
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      chk("rst.data",  {24'd0, DATA_OUT}, 32'h00);
      chk("rst.flags", {25'd0, ICWS_FLAGS, OCWS_FLAGS}, 32'd0);
      chk("rst.init",  {31'd0, INIT_DONE}, 32'd0);
      chk("rst.doe",   {31'd0, D_OE}, 32'd0);
      @(negedge CLK); RST_N = 1'b1;

      // OCW before any ICW1 is ignored
      wchk("pre_ocw", 1'b1, 8'hFF, 4'b0000, 3'b000, 8'h00, 1'b0);

      // Single, ICW4: ICW1 -> ICW2 -> ICW4, with an ignored write in WAIT_ICW2
      wchk("a.icw1", 1'b0, 8'h13, 4'b0001, 3'b000, 8'h13, 1'b0);
      wchk("a.ign",  1'b0, 8'h00, 4'b0000, 3'b000, 8'h13, 1'b0);
      wchk("a.icw2", 1'b1, 8'h20, 4'b0010, 3'b000, 8'h20, 1'b0);
      wchk("a.icw4", 1'b1, 8'h01, 4'b1000, 3'b000, 8'h01, 1'b1);

      // Operational words
      wchk("ocw1", 1'b1, 8'hF0, 4'b0000, 3'b001, 8'hF0, 1'b1);
      wchk("ocw2", 1'b0, 8'h20, 4'b0000, 3'b010, 8'h20, 1'b1);
      wchk("ocw3", 1'b0, 8'h0B, 4'b0000, 3'b100, 8'h0B, 1'b1);

      // Read-back selection
      IRR = 8'h11; ISR = 8'h44; IMR = 8'hF0;
      rchk("rd.isr", 1'b0, 8'h44, 1'b1);
      wchk("ocw3b", 1'b0, 8'h0A, 4'b0000, 3'b100, 8'h0A, 1'b1);
      rchk("rd.irr", 1'b0, 8'h11, 1'b1);
      rchk("rd.imr", 1'b1, 8'hF0, 1'b1);
      wchk("ocw3c", 1'b0, 8'h0B, 4'b0000, 3'b100, 8'h0B, 1'b1);
      wchk("ocw3n", 1'b0, 8'h08, 4'b0000, 3'b100, 8'h08, 1'b1);
      rchk("rd.keep", 1'b0, 8'h44, 1'b1);

      // Read and write strobes together: write wins, bus not driven
      @(negedge CLK);
      CS_N = 1'b0; RD_N = 1'b0; WR_N = 1'b0; A0 = 1'b1; D_IN = 8'hAA;
      #1;
      chk("rdwr.doe",  {31'd0, D_OE},  32'd0);
      chk("rdwr.dout", {24'd0, D_OUT}, 32'd0);
      @(negedge CLK);
      CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
      @(posedge CLK); #1;
      chk("rdwr.ocw",  {29'd0, OCWS_FLAGS}, 32'b001);
      chk("rdwr.data", {24'd0, DATA_OUT},   32'hAA);

      // Cascade with ICW4 from READY: passes through WAIT_ICW3
      wchk("b.icw1", 1'b0, 8'h11, 4'b0001, 3'b000, 8'h11, 1'b0);
      wchk("b.icw2", 1'b1, 8'h08, 4'b0010, 3'b000, 8'h08, 1'b0);
      wchk("b.icw3", 1'b1, 8'h04, 4'b0100, 3'b000, 8'h04, 1'b0);
      wchk("b.icw4", 1'b1, 8'h01, 4'b1000, 3'b000, 8'h01, 1'b1);

      // Reset while a write is pending in WAIT_ICW2
      wchk("c.icw1", 1'b0, 8'h13, 4'b0001, 3'b000, 8'h13, 1'b0);
      @(negedge CLK);
      CS_N = 1'b0; WR_N = 1'b0; A0 = 1'b1; D_IN = 8'h20;
      @(negedge CLK); RST_N = 1'b0;
      @(negedge CLK); RST_N = 1'b1; WR_N = 1'b1; CS_N = 1'b1;
      @(posedge CLK); #1;
      chk("c.rst.flags", {25'd0, ICWS_FLAGS, OCWS_FLAGS}, 32'd0);
      chk("c.rst.data",  {24'd0, DATA_OUT}, 32'h00);
      @(posedge CLK); #1;
      chk("c.rst.flags2", {25'd0, ICWS_FLAGS, OCWS_FLAGS}, 32'd0);
      // IDLE ignores the ICW2-shaped write that WAIT_ICW2 would accept
      wchk("c.idle", 1'b1, 8'h20, 4'b0000, 3'b000, 8'h00, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule : tb_read_write_logic
`default_nettype wire
